binary_down_counter: RTL

- Loadable binary down counter with a terminal-count pulse and a selectable underflow policy: wrap to all-ones, or auto-reload from the last loaded value.
- Counterpart to the team's loadable binary up counter; shares its data/load interface conventions.
- Used as a programmable interval/delay timer in sequential designs.

---
 rtl/binary_down_counter.sv | 74 +++++++
 1 files changed

// File: rtl/binary_down_counter.sv
// Loadable binary down counter with terminal-count pulse and selectable
// underflow policy (wrap to all-ones, or reload from the last loaded value).
//
// Ports:
//   clk          system clock, all state updates on posedge
//   rst          asynchronous active-low reset
//   din          value to load (also captured as the reload value)
//   load         synchronous load strobe, wins over en
//   en           count enable, decrement when high
//   auto_reload  underflow policy: 1 = reload, 0 = wrap to all-ones
//   count        current counter value (registered)
//   zero         combinational, count == 0
//   borrow       combinational, underflow happens on the next edge
//   tc           registered one-cycle pulse after the 1->0 decrement
module binary_down_counter #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             load,
    input  logic             en,
    input  logic             auto_reload,
    output logic [WIDTH-1:0] count,
    output logic             zero,
    output logic             borrow,
    output logic             tc
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic [WIDTH-1:0] reload_q;
    logic [WIDTH-1:0] count_d;
    logic             tc_d;

    // Next-state selection in priority order: load, decrement, underflow, hold.
    always_comb begin
        count_d = count;
        tc_d    = 1'b0;
        if (load) begin
            count_d = din;
        end else if (en) begin
            if (count > ONE) begin
                count_d = count - ONE;
            end else if (count == ONE) begin
                count_d = '0;
                tc_d    = 1'b1;
            end else if (auto_reload) begin
                count_d = reload_q;
            end else begin
                count_d = '1;
            end
        end
    end

    // State registers; reset also clears the reload value.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count    <= '0;
            reload_q <= '0;
            tc       <= 1'b0;
        end else begin
            count <= count_d;
            tc    <= tc_d;
            if (load) begin
                reload_q <= din;
            end
        end
    end

    assign zero   = (count == '0);
    assign borrow = en & ~load & zero;

endmodule
